// File: rtl/hog_block_assembler_pkg.sv
// Shared HOG block-assembly constants: default geometry, derived widths and
// the cell ordering inside a 2x2 block (shared with the normalizer).
package hog_block_assembler_pkg;

  localparam int HOG_BIN_WIDTH     = 14;
  localparam int HOG_BINS          = 9;
  localparam int HOG_CELLS_PER_ROW = 80;
  localparam int HOG_CELL_ROWS     = 60;

  localparam int HOG_CELL_WIDTH  = HOG_BIN_WIDTH * (HOG_BINS + 1);
  localparam int HOG_BLOCK_WIDTH = HOG_CELL_WIDTH * 4;

  typedef enum logic [1:0] {
    CELL_TL = 2'd0,
    CELL_TR = 2'd1,
    CELL_BL = 2'd2,
    CELL_BR = 2'd3
  } cell_idx_e;

endpackage

// File: rtl/hog_block_assembler_line_buffer.sv
// One image row of cell histograms: synchronous write, asynchronous read at
// the same address, so a read returns the previous row's cell at that column.
module hog_cell_line_buffer #(
  parameter int DEPTH  = 80,
  parameter int WIDTH  = 140,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  // No reset: row 0 of every frame refills the buffer before anything reads it out.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/hog_block_assembler.sv
// Assembles 2x2 blocks of cell histograms from a raster cell stream.
// Optional frame_done output enabled by defining HOG_BLOCK_ASM_FRAME_DONE_EN.
module hog_block_assembler
  import hog_block_assembler_pkg::*;
#(
  parameter int BIN_WIDTH     = HOG_BIN_WIDTH,
  parameter int BINS          = HOG_BINS,
  parameter int CELLS_PER_ROW = HOG_CELLS_PER_ROW,
  parameter int CELL_ROWS     = HOG_CELL_ROWS,
  parameter int CELL_WIDTH    = BIN_WIDTH * (BINS + 1),
  parameter int BLOCK_WIDTH   = CELL_WIDTH * 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   sof,
  input  logic [CELL_WIDTH-1:0]  cell_hist,
  output logic                   out_valid,
  output logic                   k_border,
  output logic [BLOCK_WIDTH-1:0] block_histograms
`ifdef HOG_BLOCK_ASM_FRAME_DONE_EN
  ,
  output logic                   frame_done
`endif
);

  localparam int COL_W = (CELLS_PER_ROW > 1) ? $clog2(CELLS_PER_ROW) : 1;
  localparam int ROW_W = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CELLS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CELL_ROWS - 1);

  logic [COL_W-1:0]      col, eff_col;
  logic [ROW_W-1:0]      row, eff_row;
  logic [CELL_WIDTH-1:0] top, tl_reg, bl_reg;
  logic                  emit;

  // A start-of-frame beat is cell (0,0) whatever the counters say.
  assign eff_col = (in_valid && sof) ? '0 : col;
  assign eff_row = (in_valid && sof) ? '0 : row;
  assign emit    = in_valid && (eff_row != '0);

  hog_cell_line_buffer #(
    .DEPTH (CELLS_PER_ROW),
    .WIDTH (CELL_WIDTH),
    .ADDR_W(COL_W)
  ) u_line_buffer (
    .clk  (clk),
    .we   (in_valid),
    .addr (eff_col),
    .wdata(cell_hist),
    .rdata(top)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col              <= '0;
      row              <= '0;
      tl_reg           <= '0;
      bl_reg           <= '0;
      out_valid        <= 1'b0;
      k_border         <= 1'b0;
      block_histograms <= '0;
    end else begin
      out_valid <= emit;
      k_border  <= emit && (eff_col == '0);
      if (in_valid) begin
        if (emit) begin
          block_histograms[int'(CELL_TL)*CELL_WIDTH +: CELL_WIDTH] <= tl_reg;
          block_histograms[int'(CELL_TR)*CELL_WIDTH +: CELL_WIDTH] <= top;
          block_histograms[int'(CELL_BL)*CELL_WIDTH +: CELL_WIDTH] <= bl_reg;
          block_histograms[int'(CELL_BR)*CELL_WIDTH +: CELL_WIDTH] <= cell_hist;
        end
        tl_reg <= top;
        bl_reg <= cell_hist;
        if (eff_col == COL_LAST) begin
          col <= '0;
          row <= (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
        end else begin
          col <= eff_col + COL_W'(1);
          row <= eff_row;
        end
      end
    end
  end

`ifdef HOG_BLOCK_ASM_FRAME_DONE_EN
  always_ff @(posedge clk) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= emit && (eff_row == ROW_LAST) && (eff_col == COL_LAST);
  end
`endif

endmodule
